// File: rtl/switch_debouncer_if.sv
// rtl/switch_debouncer_if.sv - switch conditioning bus between board pins and the switch PIO
interface switch_debouncer_if #(
    parameter int WIDTH = 5
);
    logic [WIDTH-1:0] sw_raw;
    logic             irq_ack;
    logic [WIDTH-1:0] sw_db;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             change_irq;
    logic [WIDTH-1:0] change_mask;

    modport master (
        output sw_raw,
        output irq_ack,
        input  sw_db,
        input  sw_rise,
        input  sw_fall,
        input  change_irq,
        input  change_mask
    );

    modport slave (
        input  sw_raw,
        input  irq_ack,
        output sw_db,
        output sw_rise,
        output sw_fall,
        output change_irq,
        output change_mask
    );
endinterface

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - per-bit synchronise and debounce of slide switches with edge pulses and sticky change flag
module switch_debouncer #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic           clk_clk,
    input  logic           reset_reset_n,
    switch_debouncer_if.slave bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]            sync1_q, sync1_d;
    logic [WIDTH-1:0]            sync2_q, sync2_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]            db_q, db_d;
    logic [WIDTH-1:0]            rise_q, rise_d;
    logic [WIDTH-1:0]            fall_q, fall_d;
    logic                        irq_q, irq_d;
    logic [WIDTH-1:0]            mask_q, mask_d;
    logic [WIDTH-1:0]            changed;

    always_comb begin
        sync1_d = bus.sw_raw;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        rise_d  = '0;
        fall_d  = '0;
        // Any cycle of agreement restarts the count, so only an unbroken run is accepted.
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                db_d[i]   = sync2_q[i];
                cnt_d[i]  = '0;
                rise_d[i] = sync2_q[i];
                fall_d[i] = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        changed = rise_d | fall_d;
        irq_d   = irq_q;
        mask_d  = mask_q;
        // A new edge beats a simultaneous acknowledge; the mask then keeps only the new bits.
        if (|changed) begin
            irq_d  = 1'b1;
            mask_d = (bus.irq_ack ? '0 : mask_q) | changed;
        end else if (bus.irq_ack) begin
            irq_d  = 1'b0;
            mask_d = '0;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
            db_q    <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            irq_q   <= 1'b0;
            mask_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            irq_q   <= irq_d;
            mask_q  <= mask_d;
        end
    end

    assign bus.sw_db       = db_q;
    assign bus.sw_rise     = rise_q;
    assign bus.sw_fall     = fall_q;
    assign bus.change_irq  = irq_q;
    assign bus.change_mask = mask_q;
endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - randomized scoreboard bench for switch_debouncer against a sample-window model
module tb_switch_debouncer;
    localparam int W = 5;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    switch_debouncer_if #(.WIDTH(W)) sw_if ();

    switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (sw_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] db;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         irq;
        logic [W-1:0] mask;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] hist[$];
    logic [W-1:0] m_db, m_mask;
    logic         m_irq;
    int           vectors = 0;
    int           fails   = 0;
    int           cycle   = 0;

    // Model: a level is accepted once the last D synchronised samples all differ from it.
    task automatic model_clear();
        m_db = '0; m_mask = '0; m_irq = 1'b0;
        hist.delete();
        exp_q.delete();
        for (int k = 0; k < D + 2; k++) hist.push_back('0);
    endtask

    task automatic model_step();
        exp_t         e;
        logic [W-1:0] rise, fall, s;
        logic         stable;
        hist.push_back(sw_if.sw_raw);
        void'(hist.pop_front());
        rise = '0; fall = '0;
        for (int i = 0; i < W; i++) begin
            stable = 1'b1;
            for (int k = 0; k < D; k++) begin
                s = hist[k];
                if (s[i] == m_db[i]) stable = 1'b0;
            end
            if (stable) begin
                if (m_db[i]) fall[i] = 1'b1; else rise[i] = 1'b1;
                m_db[i] = ~m_db[i];
            end
        end
        if ((rise | fall) != '0) begin
            m_irq  = 1'b1;
            m_mask = (sw_if.irq_ack ? '0 : m_mask) | rise | fall;
        end else if (sw_if.irq_ack) begin
            m_irq  = 1'b0;
            m_mask = '0;
        end
        e.db = m_db; e.rise = rise; e.fall = fall; e.irq = m_irq; e.mask = m_mask;
        exp_q.push_back(e);
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_clear();
            else model_step();
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            cycle++;
            if (rst_n) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL scoreboard cycle %0d: no expected entry queued", cycle);
                end else begin
                    e = exp_q.pop_front();
                    if (sw_if.sw_db !== e.db || sw_if.sw_rise !== e.rise || sw_if.sw_fall !== e.fall ||
                        sw_if.change_irq !== e.irq || sw_if.change_mask !== e.mask) begin
                        fails++;
                        $display("FAIL outputs cycle %0d: got db=%b rise=%b fall=%b irq=%b mask=%b, expected db=%b rise=%b fall=%b irq=%b mask=%b",
                                 cycle, sw_if.sw_db, sw_if.sw_rise, sw_if.sw_fall, sw_if.change_irq, sw_if.change_mask,
                                 e.db, e.rise, e.fall, e.irq, e.mask);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_zero(input string name);
        vectors++;
        if (sw_if.sw_db !== '0 || sw_if.sw_rise !== '0 || sw_if.sw_fall !== '0 ||
            sw_if.change_irq !== 1'b0 || sw_if.change_mask !== '0) begin
            fails++;
            $display("FAIL %s: got db=%b rise=%b fall=%b irq=%b mask=%b, expected all zero",
                     name, sw_if.sw_db, sw_if.sw_rise, sw_if.sw_fall, sw_if.change_irq, sw_if.change_mask);
        end
    endtask

    task automatic pulse_ack();
        sw_if.irq_ack = 1'b1;
        cyc(1);
        sw_if.irq_ack = 1'b0;
    endtask

    initial begin
        sw_if.sw_raw  = '0;
        sw_if.irq_ack = 1'b0;
        cyc(3);
        #1;
        check_reset_zero("power_on_reset");
        cyc(1);
        rst_n = 1'b1;
        cyc(20);

        sw_if.sw_raw = 5'b00001;
        cyc(10);

        sw_if.sw_raw[1] = 1'b1; cyc(3);
        sw_if.sw_raw[1] = 1'b0; cyc(1);
        sw_if.sw_raw[1] = 1'b1; cyc(10);

        pulse_ack();
        cyc(2);
        sw_if.sw_raw[0] = 1'b1;
        cyc(8);
        pulse_ack();
        cyc(2);
        sw_if.sw_raw[0] = 1'b0;
        cyc(5);
        pulse_ack();
        cyc(3);
        pulse_ack();
        cyc(3);

        sw_if.sw_raw[3] = 1'b1;
        cyc(4);
        rst_n = 1'b0;
        #1;
        check_reset_zero("reset_mid_count");
        sw_if.sw_raw = 5'b11111;
        cyc(2);
        rst_n = 1'b1;
        cyc(10);

        sw_if.sw_raw = '0;
        cyc(10);
        pulse_ack();
        cyc(2);
        sw_if.sw_raw[0] = 1'b1; cyc(2);
        sw_if.sw_raw[4] = 1'b1; cyc(12);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                int b;
                b = $urandom_range(0, W - 1);
                sw_if.sw_raw[b] = ~sw_if.sw_raw[b];
            end
            sw_if.irq_ack = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                #1;
                check_reset_zero("reset_random");
                cyc(2);
                rst_n = 1'b1;
            end
            cyc(1);
        end
        sw_if.irq_ack = 1'b0;
        cyc(3);

        vectors++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d expected entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
